// File: rtl/or1200_ic_biu_burst_pkg.sv
// Shared codes and helpers for the OR1200 instruction-cache line-fill BIU.
package or1200_ic_biu_burst_pkg;

   typedef enum logic [1:0] {StIdle, StBus, StDone} biu_state_e;

   localparam logic [2:0] CtiClassic = 3'b000;
   localparam logic [2:0] CtiIncr    = 3'b010;
   localparam logic [2:0] CtiEob     = 3'b111;

   localparam logic [1:0] BteLinear  = 2'b00;
   localparam logic [1:0] BteWrap4   = 2'b01;

   // First byte-address bit above the word index inside a line.
   function automatic int unsigned line_offs(input int unsigned line_words);
      return $clog2(line_words) + 2;
   endfunction

endpackage

// File: rtl/or1200_ic_biu_wrapcnt.sv
// Critical-word-first wrap index for a line fill, with a beat counter that flags
// the final beat of a full line.
module or1200_ic_biu_wrapcnt #(
   parameter int unsigned LINE_WORDS = 4,
   localparam int unsigned IW = $clog2(LINE_WORDS)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [IW-1:0] start_i,
   input  logic          adv_i,
   output logic [IW-1:0] idx_o,
   output logic          last_o
);

   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] cnt_q, cnt_d;

   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      if (load_i) begin
         idx_d = start_i;
         cnt_d = '0;
      end else if (adv_i) begin
         // LINE_WORDS is a power of two, so natural overflow is the wrap.
         idx_d = idx_q + IW'(1);
         cnt_d = cnt_q + IW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= '0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
      end
   end

   assign idx_o  = idx_q;
   assign last_o = (cnt_q == IW'(LINE_WORDS - 1));

endmodule

// File: rtl/or1200_ic_biu_burst.sv
// Instruction-cache line-fill engine: single or wrap-4 Wishbone burst reads.
// Define OR1200_IC_BIU_TIMEOUT_EN to add a no-response watchdog of TIMEOUT cycles.
module or1200_ic_biu_burst
   import or1200_ic_biu_burst_pkg::*;
#(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          biu_read,
   input  logic          burst,
   input  logic [AW-1:0] saved_addr,
   output logic          biudata_valid,
   output logic          biudata_error,
   output logic [DW-1:0] biudata_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic [AW-1:0] wb_adr_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic [DW-1:0] wb_dat_i
);

   localparam int unsigned IW   = $clog2(LINE_WORDS);
   localparam int unsigned OFFS = line_offs(LINE_WORDS);

   biu_state_e       state_q, state_d;
   logic [AW-1:OFFS] line_q, line_d;
   logic             burst_q, burst_d;
   logic             valid_q, valid_d;
   logic             error_q, error_d;
   logic [DW-1:0]    dat_q, dat_d;

   logic [IW-1:0]    idx;
   logic             cnt_last;
   logic             load, adv;
   logic             in_bus, beat_last, tmo_hit, bus_err;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = ^saved_addr[1:0];

   or1200_ic_biu_wrapcnt #(
      .LINE_WORDS (LINE_WORDS)
   ) u_wrapcnt (
      .clk_i   (clk),
      .rst_ni  (rst),
      .load_i  (load),
      .start_i (saved_addr[OFFS-1:2]),
      .adv_i   (adv),
      .idx_o   (idx),
      .last_o  (cnt_last)
   );

   assign in_bus    = (state_q == StBus);
   // A dropped biu_read turns the beat in flight into the last one.
   assign beat_last = !burst_q || cnt_last || !biu_read;
   assign bus_err   = wb_err_i || tmo_hit;

`ifdef OR1200_IC_BIU_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_hit = in_bus && (tmo_q == TW'(TIMEOUT));

   always_comb begin
      tmo_d = '0;
      if (in_bus && !wb_ack_i && !wb_err_i && !tmo_hit) tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tmo_q <= '0;
      else      tmo_q <= tmo_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      burst_d = burst_q;
      dat_d   = dat_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      load    = 1'b0;
      adv     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (biu_read) begin
               line_d  = saved_addr[AW-1:OFFS];
               burst_d = burst;
               load    = 1'b1;
               state_d = StBus;
            end
         end
         StBus: begin
            if (bus_err) begin
               error_d = 1'b1;
               state_d = StDone;
            end else if (wb_ack_i) begin
               valid_d = 1'b1;
               dat_d   = wb_dat_i;
               adv     = 1'b1;
               if (beat_last) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         line_q  <= '0;
         burst_q <= 1'b0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         burst_q <= burst_d;
         valid_q <= valid_d;
         error_q <= error_d;
         dat_q   <= dat_d;
      end
   end

   assign biudata_valid = valid_q;
   assign biudata_error = error_q;
   assign biudata_o     = dat_q;
   assign wb_cyc_o      = in_bus;
   assign wb_stb_o      = in_bus;
   assign wb_adr_o      = in_bus ? {line_q, idx, 2'b00} : '0;
   assign wb_cti_o      = (!in_bus || !burst_q) ? CtiClassic : (beat_last ? CtiEob : CtiIncr);
   assign wb_bte_o      = (in_bus && burst_q) ? BteWrap4 : BteLinear;

endmodule

// File: doc/or1200_ic_biu_burst.md
Name: or1200_ic_biu_burst

Overview:
- Bus-side line-fill engine directly downstream of the instruction-cache FSM.
- Consumes the FSM's biu_read / burst / saved_addr request and runs a single or wrap-4 burst read on the Wishbone-style instruction bus.
- Returns each beat to the FSM as biudata_valid / biudata_error plus data.
- The FSM uses these returns to write ICRAM and the tag.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LINE_WORDS, 4, words per cache line; burst length, power of two ≥2.
- TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- biu_read  in  1  request from the cache FSM; level, held while a fetch is wanted.
- burst  in  1  1 = line fill (LINE_WORDS beats), 0 = single-word read (cache-inhibited or disabled).
- saved_addr  in  AW  critical-word byte address.
- biudata_valid  out  1  one-cycle pulse per returned good beat.
- biudata_error  out  1  one-cycle pulse on a bus error or timeout.
- biudata_o  out  DW  beat data, valid with biudata_valid.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_adr_o  out  AW  beat address.
- wb_cti_o  out  3  cycle-type identifier: 3'b000 classic, 3'b010 incrementing, 3'b111 end-of-burst.
- wb_bte_o  out  2  burst-type extension: 2'b01 wrap-4 for burst, 2'b00 otherwise.
- wb_ack_i  in  1  beat acknowledge.
- wb_err_i  in  1  beat error.
- wb_dat_i  in  DW  read data.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; beat counter 0.
- States:
  - IDLE: if biu_read, latch saved_addr and burst, clear the counter, go to BUS. Bus outputs are asserted the cycle after biu_read is sampled (1-cycle request latency).
  - BUS: wb_cyc_o = wb_stb_o = 1.
    - wb_adr_o = {latched_addr[AW-1:log2(LINE_WORDS)+2], word_index, 2'b00}.
    - word_index starts at latched_addr[log2(LINE_WORDS)+1:2] and increments modulo LINE_WORDS on each ack. This is wrap-around, critical word first: start index 3 issues 3,0,1,2.
    - wb_cti_o = 3'b010 until the last beat, 3'b111 on the last beat. For a single read, wb_cti_o = 3'b000 and wb_bte_o = 2'b00.
  - On wb_ack_i in BUS:
    - Register wb_dat_i into biudata_o.
    - Pulse biudata_valid the next cycle (1-cycle return latency).
    - Increment the counter.
    - If this was the last beat (counter = LINE_WORDS-1, or a single read), drop cyc/stb the next cycle and go to DONE.
  - On wb_err_i in BUS: pulse biudata_error the next cycle, drop cyc/stb, go to DONE. Remaining beats are not issued.
  - DONE: one cycle with the bus idle, then IDLE. A new biu_read is not accepted in DONE, which guarantees a 1-cycle bus gap between transactions.
- Simultaneous events:
  - wb_ack_i and wb_err_i asserted together: error wins; no biudata_valid.
  - biu_read deasserted mid-burst (FSM abort): finish the current beat. wb_cti_o switches to 3'b111 on that beat; then go to DONE. Its ack still produces biudata_valid.
  - biu_read asserted in IDLE while burst=0: single read, exactly one beat.
- saved_addr and burst changing during BUS are ignored (latched copies are used).
- biudata_valid and biudata_error are never high in the same cycle.
- biudata_valid count per request ≤ LINE_WORDS.
- Reset asserted mid-burst: bus outputs drop immediately (asynchronously); no further pulses.

Optional Feature:
- Macro: OR1200_IC_BIU_TIMEOUT_EN.
- Defined: a cycle counter runs while in BUS without ack or err. It clears on each ack. Reaching TIMEOUT is treated exactly as wb_err_i: biudata_error pulse, bus released, DONE.
- Undefined: no counter; BUS waits indefinitely; TIMEOUT is unused.

Decomposition:
- Shared package or defines file: CTI codes (CLASSIC, INCR, EOB), BTE codes (LINEAR, WRAP4), state encoding (IDLE, BUS, DONE), and the log2(LINE_WORDS) offset constant.
- One natural sub-module: or1200_ic_biu_wrapcnt, the modulo-LINE_WORDS wrap index generator with a last-beat flag.

Test Plan:
- Burst from saved_addr=0x0000_100C, acks every cycle:
  - addresses 0x100C, 0x1000, 0x1004, 0x1008;
  - cti 010, 010, 010, 111; bte=01;
  - 4 biudata_valid pulses with matching data; cyc drops 1 cycle after the 4th ack.
- Single read (burst=0), addr 0x2004, ack after 3 wait cycles: cti=000; one biudata_valid carrying wb_dat_i; bus idle in DONE for 1 cycle.
- Burst from 0x3000 with wb_err_i on beat 2 (addr 0x3004): exactly 1 biudata_valid then 1 biudata_error; beats 0x3008 and 0x300C are never issued.
- biu_read dropped after the first ack of a burst at 0x4008:
  - second beat 0x400C issued with cti=111;
  - 2 biudata_valid pulses total, then IDLE.
- rst driven low while in BUS mid-burst: wb_cyc_o, wb_stb_o, biudata_valid and biudata_error all 0 within the same cycle; after rst=1, a new request starts from IDLE.
- With OR1200_IC_BIU_TIMEOUT_EN and TIMEOUT=8, no ack for a single read: biudata_error pulses once, 9 cycles after stb rises; bus released.
